// File: rtl/log_capture.sv
// Block-RAM sample capture buffer with one-shot fill and circular pre-trigger modes.
// Samples enter on wr/din during capture; the host drains them oldest-first on rd/dout once done.
module log_capture #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          mode,
  input  logic [AW:0]   post_len,
  input  logic          trig,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          triggered,
  output logic          dropped
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PRE, S_POST, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [AW:0]   post_len_q, post_len_d;
  logic          mode_q, mode_d;
  logic          triggered_q, triggered_d;
  logic          dropped_q, dropped_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] raddr_d;
  logic          mem_we;
  logic          rd_adv;
  logic [DW-1:0] dout_q;

  logic [DW-1:0] mem [DEPTH];

  // Circular occupancy: saturate at DEPTH once the oldest sample starts being overwritten.
  function automatic logic [AW:0] circ_count(input logic [AW:0] c);
    return (c == FULL) ? c : c + (AW+1)'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    post_len_d  = post_len_q;
    mode_d      = mode_q;
    triggered_d = triggered_q;
    dropped_d   = dropped_q;
    mem_we      = 1'b0;
    rd_adv      = rd && (state_q == S_DONE) && (count_q != '0);

    if (arm) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      triggered_d = 1'b0;
      dropped_d   = 1'b0;
      mode_d      = mode;
      post_len_d  = post_len;
      state_d     = mode ? S_PRE : S_FILL;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (wr) begin
            mem_we  = 1'b1;
            wptr_d  = wptr_q + AW'(1);
            count_d = count_q + (AW+1)'(1);
            if (count_q == FULL - (AW+1)'(1)) state_d = S_DONE;
          end
        end
        S_PRE: begin
          if (trig) begin
            triggered_d = 1'b1;
            if (post_len_q == '0) begin
              state_d = S_DONE;
            end else if (wr) begin
              // The trigger-cycle sample already counts as post-trigger data.
              mem_we      = 1'b1;
              wptr_d      = wptr_q + AW'(1);
              count_d     = circ_count(count_q);
              remaining_d = post_len_q - (AW+1)'(1);
              state_d     = (post_len_q == (AW+1)'(1)) ? S_DONE : S_POST;
            end else begin
              remaining_d = post_len_q;
              state_d     = S_POST;
            end
          end else if (wr) begin
            mem_we  = 1'b1;
            wptr_d  = wptr_q + AW'(1);
            count_d = circ_count(count_q);
          end
        end
        S_POST: begin
          if (wr && remaining_q != '0) begin
            mem_we      = 1'b1;
            wptr_d      = wptr_q + AW'(1);
            count_d     = circ_count(count_q);
            remaining_d = remaining_q - (AW+1)'(1);
            if (remaining_q == (AW+1)'(1)) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (wr) dropped_d = 1'b1;
          if (rd_adv) begin
            rptr_d  = rptr_q + AW'(1);
            count_d = count_q - (AW+1)'(1);
          end
        end
        default: ;
      endcase
    end

    // On entry to DONE point the reader at the oldest surviving sample.
    if (state_d == S_DONE && state_q != S_DONE) rptr_d = wptr_d - count_d[AW-1:0];

    busy_d  = (state_d == S_FILL) || (state_d == S_PRE) || (state_d == S_POST);
    done_d  = (state_d == S_DONE);
    raddr_d = rptr_q + {{(AW-1){1'b0}}, rd_adv};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      post_len_q  <= '0;
      mode_q      <= 1'b0;
      triggered_q <= 1'b0;
      dropped_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      post_len_q  <= post_len_d;
      mode_q      <= mode_d;
      triggered_q <= triggered_d;
      dropped_q   <= dropped_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Simple dual-port RAM: port A writes at wptr, port B reads registered at raddr.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q] <= din;
    dout_q <= mem[raddr_d];
  end

  assign dout      = dout_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign triggered = triggered_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_log_capture.sv
// Directed bench for log_capture (DW=16, AW=4): reset, one-shot, circular trigger, post_len=0, re-arm.
module tb_log_capture;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          mode = 1'b0;
  logic [AW:0]   post_len = '0;
  logic          trig = 1'b0;
  logic          wr = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd = 1'b0;
  logic [DW-1:0] dout;
  logic [AW:0]   count;
  logic          busy, done, triggered, dropped;

  int vectors = 0;
  int miscompares = 0;

  log_capture #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .mode(mode), .post_len(post_len),
    .trig(trig), .wr(wr), .din(din), .rd(rd), .dout(dout), .count(count),
    .busy(busy), .done(done), .triggered(triggered), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input logic m, input logic [AW:0] pl);
    arm = 1'b1; mode = m; post_len = pl;
    tick();
    arm = 1'b0;
  endtask

  task automatic put(input logic [DW-1:0] d, input logic t);
    wr = 1'b1; din = d; trig = t;
    tick();
    wr = 1'b0; trig = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [DW-1:0] exp);
    chk(tag, 32'(dout), 32'(exp));
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and reset mid-capture
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(count), 0);
    do_arm(1'b0, '0);
    chk("fill_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) put(16'(i), 1'b0);
    chk("fill5_count", 32'(count), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_trig", 32'(triggered), 0);
    rd = 1'b1; tick(); tick(); rd = 1'b0;
    chk("midrst_rd_count", 32'(count), 0);
    chk("midrst_rd_done", 32'(done), 0);

    // One-shot fill with overflow
    do_arm(1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      put(16'h0100 + 16'(i), 1'b0);
      if (i == 14) chk("oneshot_notdone15", 32'(done), 0);
      if (i == 15) chk("oneshot_done16", 32'(done), 1);
    end
    chk("oneshot_count", 32'(count), 16);
    chk("oneshot_dropped", 32'(dropped), 1);
    chk("oneshot_busy", 32'(busy), 0);
    for (int i = 0; i < 16; i++) read_expect("oneshot_rd", 16'h0100 + 16'(i));
    chk("oneshot_empty", 32'(count), 0);
    rd = 1'b1; tick(); rd = 1'b0;
    chk("oneshot_rd_ignored", 32'(count), 0);
    chk("oneshot_still_done", 32'(done), 1);

    // Circular pre-trigger, post_len=4, trigger with sample 25
    do_arm(1'b1, 5'd4);
    chk("circ_busy", 32'(busy), 1);
    chk("circ_dropped_clr", 32'(dropped), 0);
    for (int i = 1; i <= 30; i++) begin
      put(16'(i), i == 25);
      if (i == 20) chk("circ_sat_count", 32'(count), 16);
      if (i == 27) chk("circ_post_busy", 32'(busy), 1);
      if (i == 28) chk("circ_done", 32'(done), 1);
    end
    chk("circ_trig", 32'(triggered), 1);
    chk("circ_dropped", 32'(dropped), 1);
    chk("circ_count", 32'(count), 16);
    for (int i = 13; i <= 28; i++) read_expect("circ_rd", 16'(i));

    // Short pre-history, post_len=2
    do_arm(1'b1, 5'd2);
    chk("short_trig_clr", 32'(triggered), 0);
    put(16'd1, 1'b0); put(16'd2, 1'b0); put(16'd3, 1'b0);
    put(16'd4, 1'b1);
    chk("short_not_done", 32'(done), 0);
    put(16'd5, 1'b0);
    chk("short_done", 32'(done), 1);
    chk("short_count", 32'(count), 5);
    chk("short_trig", 32'(triggered), 1);
    chk("short_dropped", 32'(dropped), 0);
    tick();
    for (int i = 1; i <= 5; i++) read_expect("short_rd", 16'(i));
    chk("short_empty", 32'(count), 0);

    // post_len=0: trigger sample not stored
    do_arm(1'b1, 5'd0);
    for (int i = 1; i <= 7; i++) put(16'h0200 + 16'(i), 1'b0);
    put(16'h0208, 1'b1);
    chk("pl0_done", 32'(done), 1);
    chk("pl0_count", 32'(count), 7);
    tick();
    for (int i = 1; i <= 3; i++) read_expect("pl0_rd", 16'h0200 + 16'(i));
    chk("pl0_partial_count", 32'(count), 4);

    // Re-arm after partial readout
    do_arm(1'b0, '0);
    chk("rearm_count", 32'(count), 0);
    chk("rearm_busy", 32'(busy), 1);
    chk("rearm_done", 32'(done), 0);
    chk("rearm_dropped", 32'(dropped), 0);
    chk("rearm_trig", 32'(triggered), 0);
    put(16'hA000, 1'b1);
    chk("fill_trig_ignored", 32'(triggered), 0);
    for (int i = 1; i < 16; i++) put(16'hA000 + 16'(i), 1'b0);
    chk("rearm_full_done", 32'(done), 1);
    chk("rearm_full_dropped", 32'(dropped), 0);
    tick();
    for (int i = 0; i < 4; i++) read_expect("rearm_rd", 16'hA000 + 16'(i));
    chk("rearm_remaining", 32'(count), 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/log_capture.md
Name: log_capture

Overview:
- Parametrised successor to the single-mode 16-bit/1K debug logger: a block-RAM sample capture buffer for firmware diagnostics (NCO phase, correlator sums, tracking-loop state).
- Generalised in data width and depth.
- Adds an arm/done protocol, a one-shot fill mode and a circular pre-trigger mode with programmable post-trigger length, occupancy count and a sticky drop flag.
- Sits between a datapath sample source (`wr`/`din`) and the host register read port (`rd`/`dout`).

Parameters:
- DW, 16, sample/data width in bits.
- AW, 10, address width; DEPTH = 2^AW entries.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- arm  in  1  one-cycle pulse: clear buffer, latch mode/post_len, start capture
- mode  in  1  0 = one-shot fill, 1 = circular with trigger; sampled on arm
- post_len  in  AW+1  post-trigger sample count for mode 1; sampled on arm
- trig  in  1  trigger strobe, honoured only in PRE state
- wr  in  1  sample strobe
- din  in  DW  sample data
- rd  in  1  read-advance strobe, honoured only in DONE with count>0
- dout  out  DW  sample at read pointer (oldest unread)
- count  out  AW+1  entries stored (capture) / entries unread (DONE)
- busy  out  1  state is FILL, PRE or POST
- done  out  1  state is DONE
- triggered  out  1  sticky: trigger accepted since last arm
- dropped  out  1  sticky: wr seen in DONE, or seen in FILL while full

Behaviour:
- States: IDLE, FILL, PRE, POST, DONE. Reset → IDLE.
- Reset values: wptr=0, rptr=0, count=0, busy=0, done=0, triggered=0, dropped=0. dout is undefined until the first DONE entry.
- arm, from any state including mid-capture:
  - clears pointers, count, triggered and dropped;
  - latches mode and post_len;
  - next state is FILL (mode 0) or PRE (mode 1);
  - wr on the arm cycle is ignored.
- FILL:
  - wr writes din at wptr; wptr++, count++.
  - When count reaches DEPTH, go to DONE on the same edge as the final write.
  - FILL is left only by reaching full, arm or rst.
- PRE:
  - wr writes at wptr; wptr wraps modulo DEPTH; count saturates at DEPTH, overwriting the oldest sample.
  - trig sets triggered and moves to POST with remaining = post_len.
  - A wr on the trigger cycle is a post-trigger write: it is stored and decrements remaining.
- POST:
  - wr writes only while remaining>0; each write decrements remaining. Circular overwrite and count saturation as in PRE.
  - When remaining reaches 0, go to DONE.
  - post_len=0: trig goes to DONE directly and the trigger-cycle sample is not stored.
  - post_len≥DEPTH is legal; the buffer then holds only post-trigger data.
  - trig in POST/FILL/DONE/IDLE is ignored.
- Entering DONE sets rptr = (wptr − count) mod DEPTH, i.e. the oldest entry.
- Read port:
  - Synchronous RAM read at address rptr + (rd & ok), where ok = done & count>0.
  - dout shows mem[rptr] from the second cycle in DONE onward.
  - An accepted rd advances rptr (wrapping) and decrements count; dout shows the next entry on the following cycle.
  - rd with count=0 or outside DONE changes nothing.
- DONE:
  - wr sets dropped and is not stored.
  - Remains until arm or rst, even when count reaches 0.
- IDLE: wr, rd and trig are ignored; dropped is not set.
- wr and rd in the same cycle cannot conflict: writes occur only in capture states, reads only in DONE.
- RAM is a simple dual-port block (write port A, read port B), inferred or instantiated. RAM contents are not cleared by rst or arm.

Test Plan (DW=16, AW=4, DEPTH=16):
- Reset mid-capture: arm mode 0, write 5 samples, assert rst → next cycle busy=0, done=0, count=0, triggered=0; rd pulses have no effect.
- One-shot: arm mode 0, wr 20 consecutive samples 0x0100..0x0113 → done after 16th write, count=16, dropped=1; 16 rd pulses read 0x0100..0x010F in order, then count=0 and further rd is ignored.
- Circular pre-trigger: arm mode 1 post_len=4, wr samples 1..30, trig coincident with sample 25 → samples 25..28 stored, 29..30 dropped (dropped=1), done=1, count=16; readout is 13..28.
- Short pre-history: arm mode 1 post_len=2, wr samples 1..3, trig with sample 4, wr sample 5 → count=5, readout 1,2,3,4,5, triggered=1.
- post_len=0: arm mode 1, wr 7 samples, trig with wr of sample 8 → done next cycle, count=7, readout 1..7.
- Re-arm: in DONE after partial readout (3 rd pulses), arm mode 0 → count=0, busy=1, dropped=0, triggered=0; fresh samples are read back from rptr=0.
